// File: rtl/mesi_isc_flex_fifo.sv
// Show-ahead valid/ready FIFO of arbitrary depth with occupancy, almost-full and sync flush.
// Optional sticky debug error flags are built only when MESI_ISC_FIFO_DBG_EN is defined.
module mesi_isc_flex_fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned AF_THRESH  = DEPTH - 1,
  parameter int unsigned CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  input  logic                  wr_valid_i,
  output logic                  wr_ready_o,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  output logic                  rd_valid_o,
  input  logic                  rd_ready_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic [CNT_W-1:0]      count_o,
  output logic                  almost_full_o,
  output logic [1:0]            dbg_err_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam ptr_t PTR_LAST = ptr_t'(DEPTH - 1);
  localparam cnt_t CNT_FULL = cnt_t'(DEPTH);
  localparam cnt_t CNT_AF   = cnt_t'(AF_THRESH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  ptr_t ptr_wr_q, ptr_wr_d;
  ptr_t ptr_rd_q, ptr_rd_d;
  cnt_t count_q,  count_d;
  logic wr_ready_q, wr_ready_d;
  logic rd_valid_q, rd_valid_d;
  logic af_q,       af_d;

  logic push;
  logic pop;
  logic mem_we;

  // Wrap by explicit compare so non power-of-2 depths never address a hole.
  function automatic ptr_t next_ptr(input ptr_t p);
    return (p == PTR_LAST) ? '0 : p + ptr_t'(1);
  endfunction

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    push       = wr_valid_i & wr_ready_q;
    pop        = rd_valid_q & rd_ready_i;
    mem_we     = push & ~flush_i;
    ptr_wr_d   = ptr_wr_q;
    ptr_rd_d   = ptr_rd_q;
    count_d    = count_q;

    if (flush_i) begin
      ptr_wr_d = '0;
      ptr_rd_d = '0;
      count_d  = '0;
    end else begin
      if (push) ptr_wr_d = next_ptr(ptr_wr_q);
      if (pop)  ptr_rd_d = next_ptr(ptr_rd_q);
      unique case ({push, pop})
        2'b10:   count_d = count_q + cnt_t'(1);
        2'b01:   count_d = count_q - cnt_t'(1);
        default: count_d = count_q;
      endcase
    end

    // Flags are derived from the next count so they move in step with count_o.
    wr_ready_d = (count_d != CNT_FULL);
    rd_valid_d = (count_d != '0);
    af_d       = (count_d >= CNT_AF);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_wr_q   <= '0;
      ptr_rd_q   <= '0;
      count_q    <= '0;
      wr_ready_q <= 1'b1;
      rd_valid_q <= 1'b0;
      af_q       <= 1'b0;
    end else begin
      ptr_wr_q   <= ptr_wr_d;
      ptr_rd_q   <= ptr_rd_d;
      count_q    <= count_d;
      wr_ready_q <= wr_ready_d;
      rd_valid_q <= rd_valid_d;
      af_q       <= af_d;
    end
  end

  // NOTE: storage is reset here because the head word must read as zero out of reset;
  // a memory that may power up random would omit the reset and map onto RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[ptr_wr_q] <= wr_data_i;
    end
  end

`ifdef MESI_ISC_FIFO_DBG_EN
  logic [1:0] dbg_err_q, dbg_err_d;

  always_comb begin
    dbg_err_d    = dbg_err_q;
    dbg_err_d[0] = dbg_err_q[0] | (wr_valid_i & ~wr_ready_q & ~rd_ready_i);
    dbg_err_d[1] = dbg_err_q[1] | (rd_ready_i & ~rd_valid_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) dbg_err_q <= '0;
    else     dbg_err_q <= dbg_err_d;
  end

  assign dbg_err_o = dbg_err_q;
`else
  assign dbg_err_o = 2'b00;
`endif

  assign wr_ready_o    = wr_ready_q;
  assign rd_valid_o    = rd_valid_q;
  assign almost_full_o = af_q;
  assign count_o       = count_q;
  assign rd_data_o     = mem_q[ptr_rd_q];

endmodule
